// File: rtl/jk_pkg.sv
// Shared J/K pair encoding and helpers for the JK-cell mod counter.
// The JKCNT_SATURATE_EN macro is consumed by jk_mod_counter, not here.
package jk_pkg;

  // {J,K} pair applied to one JK cell
  typedef logic [1:0] jk_pair_t;

  localparam jk_pair_t JK_HOLD = 2'b00;
  localparam jk_pair_t JK_RST  = 2'b01;
  localparam jk_pair_t JK_SET  = 2'b10;
  localparam jk_pair_t JK_TGL  = 2'b11;

  // How the next value is presented to the cells this cycle
  typedef enum logic [1:0] {
    DRV_HOLD = 2'b00,
    DRV_TGL  = 2'b01,
    DRV_SR   = 2'b10
  } drv_mode_e;

  // Toggle form: a bit gets J=K=1 only when it has to change
  function automatic jk_pair_t jk_from_next(input logic q_i, input logic next_i);
    return (q_i ^ next_i) ? JK_TGL : JK_HOLD;
  endfunction

  // Set/reset form: independent of the present bit value
  function automatic jk_pair_t jk_force(input logic next_i);
    return next_i ? JK_SET : JK_RST;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One clocked JK storage bit, synchronous active-high clear.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MOD counter: computes J/K pairs per bit and feeds an array of jk_cell.
// Define JKCNT_SATURATE_EN to saturate at the limits instead of wrapping.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         wrap
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [W-1:0]        nxt;
  drv_mode_e           mode;
  logic                wrap_evt;
  logic                at_top, at_bot, in_range, limit;
  jk_pair_t [W-1:0]    jk;

  assign at_top   = (q == MAXV);
  assign at_bot   = (q == '0);
  assign in_range = (q <= MAXV);
  assign limit    = up ? at_top : at_bot;

  assign tc = en & ((up & at_top) | (~up & at_bot));

  always_comb begin
    nxt      = q;
    mode     = DRV_HOLD;
    wrap_evt = 1'b0;
    if (load) begin
      nxt  = (load_val > MAXV) ? MAXV : load_val;
      mode = DRV_SR;
    end else if (en) begin
      if (!in_range) begin
        // corrupted state recovers to zero on the next count edge
        nxt  = '0;
        mode = DRV_SR;
      end else if (limit) begin
        wrap_evt = 1'b1;
`ifdef JKCNT_SATURATE_EN
        nxt  = q;
        mode = DRV_HOLD;
`else
        nxt  = up ? '0 : MAXV;
        mode = DRV_SR;
`endif
      end else begin
        nxt  = up ? q + W'(1) : q - W'(1);
        mode = DRV_TGL;
      end
    end
  end

  function automatic jk_pair_t jk_sel(input drv_mode_e m, input logic q_i, input logic n_i);
    unique case (m)
      DRV_TGL: return jk_from_next(q_i, n_i);
      DRV_SR:  return jk_force(n_i);
      default: return JK_HOLD;
    endcase
  endfunction

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign jk[i] = jk_sel(mode, q[i], nxt[i]);

    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk[i][1]),
      .k   (jk[i][0]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_evt;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench: vector table, mod-8 corner sequence and randomized model compare.
module tb_jk_mod_counter;

  localparam int MOD  = 10;
  localparam int MOD8 = 8;
`ifdef JKCNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load, tc, wrap;
  logic [3:0] load_val, q;
  logic       rst8, en8, up8, load8, tc8, wrap8;
  logic [2:0] load_val8, q8;

  jk_mod_counter #(.W(4), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
  );

  jk_mod_counter #(.W(3), .MOD(MOD8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8),
    .load_val(load_val8), .q(q8), .tc(tc8), .wrap(wrap8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, load;
    logic [3:0] lv;
    logic       en, up;
    logic       chk_tc, tc;
    logic [3:0] q;
    logic       w;
    logic       chk_jk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic ld, input int lv, input logic e, input logic u,
                     input logic ct, input logic t, input int eq, input logic w, input logic cj);
    vec_t v;
    v.rst = r; v.load = ld; v.lv = 4'(lv); v.en = e; v.up = u;
    v.chk_tc = ct; v.tc = t; v.q = 4'(eq); v.w = w; v.chk_jk = cj;
    tbl.push_back(v);
  endtask

  task automatic step8(input logic r, input logic ld, input int lv, input logic e, input logic u,
                       input logic et, input int eq, input logic ew, input string nm);
    rst8 = r; load8 = ld; load_val8 = 3'(lv); en8 = e; up8 = u;
    #1;
    chk({nm, "_tc"}, int'(tc8), int'(et));
    @(posedge clk); #1;
    chk({nm, "_q"}, int'(q8), eq);
    chk({nm, "_wrap"}, int'(wrap8), int'(ew));
    @(negedge clk);
  endtask

  initial begin
    int m, b, a;
    logic ew, et;
    rst = 1; en = 1; up = 1; load = 0; load_val = 0;
    rst8 = 1; en8 = 1; up8 = 1; load8 = 0; load_val8 = 0;

    // reset held two edges
    add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    // twelve up counts through the wrap (or into saturation)
    for (int i = 0; i < 12; i++) begin
      b = SAT ? ((i > 9) ? 9 : i) : i % 10;
      a = SAT ? ((i + 1 > 9) ? 9 : i + 1) : (i + 1) % 10;
      add(0, 0, 0, 1, 1, 1, logic'(b == 9), a, logic'(i == 9 || (SAT && i > 9)), 0);
    end
    // down from zero
    add(0, 1, 0, 1, 1, 1, SAT, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, SAT ? 0 : 9, 1, 0);
    if (SAT) begin
      add(0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
      add(0, 1, 9, 1, 1, 1, 0, 9, 0, 0);
    end
    add(0, 0, 0, 1, 0, 1, 0, 8, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 7, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 6, 0, 0);
    // load, clamp, reset beats load
    add(0, 1, 7, 1, 1, 1, 0, 7, 0, 0);
    add(0, 1, 13, 1, 1, 1, 0, 9, 0, 0);
    add(1, 1, 5, 1, 1, 1, 1, 0, 0, 0);
    // hold with direction toggling
    add(0, 1, 4, 1, 1, 1, 0, 4, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, logic'(i % 2), 1, 0, 4, 0, 1);
    // load at the limit produces no wrap; direction change on the same edge
    add(0, 1, 9, 1, 1, 1, 0, 9, 0, 0);
    add(0, 1, 3, 1, 1, 1, 1, 3, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 2, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 3, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; load = tbl[i].load; load_val = tbl[i].lv;
      en = tbl[i].en; up = tbl[i].up;
      #1;
      if (tbl[i].chk_tc) chk($sformatf("tbl%0d_tc", i), int'(tc), int'(tbl[i].tc));
      if (tbl[i].chk_jk) chk($sformatf("tbl%0d_jk_hold", i), int'(dut.jk), 0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_q", i), int'(q), int'(tbl[i].q));
      chk($sformatf("tbl%0d_wrap", i), int'(wrap), int'(tbl[i].w));
      @(negedge clk);
    end

    // full-binary modulus: wrap 7->0, mid-run reset, down wrap
    step8(1, 0, 0, 1, 1, 0, 0, 0, "m8_rst");
    step8(0, 1, 7, 1, 1, 0, 7, 0, "m8_ld7");
    step8(0, 0, 0, 1, 1, 1, SAT ? 7 : 0, 1, "m8_wrap");
    step8(0, 1, 4, 1, 1, SAT, 4, 0, "m8_ld4");
    step8(0, 0, 0, 1, 1, 0, 5, 0, "m8_up5");
    step8(1, 0, 0, 1, 1, 0, 0, 0, "m8_midrst");
    step8(0, 0, 0, 1, 0, 1, SAT ? 0 : 7, 1, "m8_down");

    // randomized run against an arithmetic model
    rst = 1; load = 0; en = 0; up = 1; load_val = 0;
    @(posedge clk); #1;
    m = 0;
    chk("rand_rst_q", int'(q), 0);
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom);
      #1;
      et = en && ((up && m == MOD - 1) || (!up && m == 0));
      chk($sformatf("rand%0d_tc", c), int'(tc), int'(et));
      @(posedge clk); #1;
      ew = 1'b0;
      if (rst) m = 0;
      else if (load) m = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      else if (en) begin
        if ((up && m == MOD - 1) || (!up && m == 0)) begin
          ew = 1'b1;
          if (!SAT) m = up ? 0 : MOD - 1;
        end else begin
          m = (m + (up ? 1 : MOD - 1)) % MOD;
        end
      end
      chk($sformatf("rand%0d_q", c), int'(q), m);
      chk($sformatf("rand%0d_wrap", c), int'(wrap), int'(ew));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
